thermo_ctrl_mc: RTL and testbench
=================================

# thermo_ctrl_mc

Multi-channel thermostat controller. Each of N_CH independent channels runs a three-state heat/idle/cool machine on sampled temperatures, with parametrised hysteresis thresholds. It adds a minimum-dwell lockout against short-cycling and a critical override that bypasses the lockout. It sits between the temperature sampling front end and the heater/cooler drive logic, and supersedes the single-channel fixed-threshold 5-bit controller.

## Interface
- TEMP_W, 5: unsigned temperature width.
- N_CH, 2: number of independent channels.
- HEAT_ON, 12: IDLE→HEAT when temp < HEAT_ON.
- COOL_ON, 18: IDLE→COOL when temp > COOL_ON.
- HEAT_OFF, 20: HEAT→IDLE when temp > HEAT_OFF.
- COOL_OFF, 14: COOL→IDLE when temp < COOL_OFF.
- CRIT_HI, 26: any state→COOL when temp > CRIT_HI; ignores dwell.
- CRIT_LO, 8: any state→HEAT when temp < CRIT_LO; ignores dwell.
- DWELL_CYC, 4: minimum clock cycles spent in a state before a non-critical exit; must be ≥1.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- temp_valid  in  N_CH  per-channel sample strobe.
- temp  in  N_CH*TEMP_W  channel i at bits [i*TEMP_W +: TEMP_W].
- mode  out  2*N_CH  channel i at [2i+:2]; 00 IDLE, 10 HEAT, 01 COOL.
- mode_chg  out  N_CH  one-cycle pulse on any state change.
- crit  out  N_CH  one-cycle pulse when a change was critical-triggered.
- dwell_ok  out  N_CH  high when the dwell counter equals DWELL_CYC.

## Operation
- Each channel has a state register and a dwell counter of width $clog2(DWELL_CYC+1).
- The counter clears to 0 on the edge a state is entered, then increments each cycle and saturates at DWELL_CYC.
- Decisions are evaluated only on an edge where temp_valid[i]=1. With valid=0, state holds and the counter keeps running.
- Priority for a valid sample, evaluated in order:
  - temp > CRIT_HI → COOL;
  - else temp < CRIT_LO → HEAT;
  - else if dwell_ok, apply the normal rule for the current state;
  - else hold.
- A critical rule whose target equals the current state produces no change and no pulse.
- Normal rules:
  - IDLE: temp < HEAT_ON → HEAT; temp > COOL_ON → COOL.
  - HEAT: temp > HEAT_OFF → IDLE.
  - COOL: temp < COOL_OFF → IDLE.
  - All other values hold.
- All comparisons are unsigned, full TEMP_W width, and strict. A temp equal to a threshold holds.
- A valid sample that is blocked by dwell is dropped, not queued.
- Channels are fully independent; simultaneous valids on several channels are all processed on the same edge.
- Elaboration-time checks; a violation is a fatal error:
  - CRIT_LO < COOL_OFF
  - HEAT_ON < COOL_ON
  - HEAT_OFF < CRIT_HI
  - every threshold ≤ 2^TEMP_W−1

## Timing
- Reset values: mode=00 (IDLE), counter=DWELL_CYC, dwell_ok=1, mode_chg=0, crit=0, for all channels.
- Reset acts immediately on assertion, even mid-cycle and mid-dwell; state and counter are lost.
- Latency is 1 cycle: a sample valid before edge k updates mode at edge k. mode_chg and crit are asserted for the cycle following edge k only.
- After entering a state at edge e, dwell_ok rises after edge e+DWELL_CYC. The earliest non-critical exit is at edge e+DWELL_CYC+1.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package thermo_pkg holds:
  - the state enum: IDLE=2'b00, HEAT=2'b10, COOL=2'b01;
  - the mode width constant.
- Sub-module thermo_chan implements one channel: FSM, dwell counter and pulse generation. It takes the thresholds and DWELL_CYC as parameters.
- thermo_ctrl_mc instantiates N_CH thermo_chan instances in a generate loop and slices the buses.

## Test plan
- Reset: assert rst with arbitrary temp and valid → all mode=00, dwell_ok=1, mode_chg=0, crit=0. The same holds when rst is asserted between edges.
- Entry: after reset, ch0 valid temp=10 → next edge mode[1:0]=10, mode_chg[0]=1 for one cycle, crit[0]=0. ch1 stays 00 with no pulse.
- Dwell: ch0 enters HEAT at edge e; valid temp=21 held from then on → mode stays HEAT through edge e+DWELL_CYC, becomes 00 at edge e+DWELL_CYC+1.
- Critical override: ch0 in HEAT, one cycle after entry, valid temp=27 → COOL at the next edge, with mode_chg[0]=1 and crit[0]=1 pulses.
- Hysteresis and equality, with dwell satisfied:
  - IDLE, temps 12 and 18 → hold; 19 → COOL.
  - In COOL, temps 14 and 15 → hold; 13 → IDLE.
  - In IDLE, temp 7 → HEAT with crit=1.
- Parametrisation: TEMP_W=8, N_CH=4, DWELL_CYC=1, thresholds ×8 (HEAT_ON=96, COOL_ON=144, HEAT_OFF=160, COOL_OFF=112, CRIT_HI=208, CRIT_LO=64), simultaneous valids on all channels (temps 90, 150, 120, 220) → modes 10, 01, 00, 01 on the same edge; crit only on ch3.

Source files
------------

// File: rtl/thermo_pkg.sv
// ---------------------------------------------------------------------------
// thermo_pkg : shared state encoding and mode width for thermo_ctrl_mc
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package thermo_pkg;
  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    IDLE = 2'b00,
    HEAT = 2'b10,
    COOL = 2'b01
  } state_t;
endpackage

`default_nettype wire

// File: rtl/thermo_ctrl_mc_if.sv
// ---------------------------------------------------------------------------
// thermo_ctrl_mc_if : sample/mode bus between sampling front end and controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface thermo_ctrl_mc_if #(
  parameter int N_CH   = 2,
  parameter int TEMP_W = 5
);
  import thermo_pkg::*;

  logic [N_CH-1:0]        temp_valid;
  logic [N_CH*TEMP_W-1:0] temp;
  logic [N_CH*MODE_W-1:0] mode;
  logic [N_CH-1:0]        mode_chg;
  logic [N_CH-1:0]        crit;
  logic [N_CH-1:0]        dwell_ok;

  modport master (
    output temp_valid, temp,
    input  mode, mode_chg, crit, dwell_ok
  );

  modport slave (
    input  temp_valid, temp,
    output mode, mode_chg, crit, dwell_ok
  );
endinterface

`default_nettype wire

// File: rtl/thermo_chan.sv
// ---------------------------------------------------------------------------
// thermo_chan : one heat/idle/cool channel with dwell lockout and critical override
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module thermo_chan
  import thermo_pkg::*;
#(
  parameter int TEMP_W    = 5,
  parameter int HEAT_ON   = 12,
  parameter int COOL_ON   = 18,
  parameter int HEAT_OFF  = 20,
  parameter int COOL_OFF  = 14,
  parameter int CRIT_HI   = 26,
  parameter int CRIT_LO   = 8,
  parameter int DWELL_CYC = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              valid,
  input  wire logic [TEMP_W-1:0] temp,
  output logic [MODE_W-1:0]      mode,
  output logic                   mode_chg,
  output logic                   crit,
  output logic                   dwell_ok
);
  localparam int              CNT_W   = $clog2(DWELL_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_CYC);

  localparam logic [TEMP_W-1:0] T_HEAT_ON  = TEMP_W'(HEAT_ON);
  localparam logic [TEMP_W-1:0] T_COOL_ON  = TEMP_W'(COOL_ON);
  localparam logic [TEMP_W-1:0] T_HEAT_OFF = TEMP_W'(HEAT_OFF);
  localparam logic [TEMP_W-1:0] T_COOL_OFF = TEMP_W'(COOL_OFF);
  localparam logic [TEMP_W-1:0] T_CRIT_HI  = TEMP_W'(CRIT_HI);
  localparam logic [TEMP_W-1:0] T_CRIT_LO  = TEMP_W'(CRIT_LO);

  state_t           state;
  state_t           nxt_state;
  logic             nxt_crit;
  logic             change;
  logic [CNT_W-1:0] cnt;

  // Critical limits are checked first and ignore the dwell lockout.
  always_comb begin
    nxt_state = state;
    nxt_crit  = 1'b0;
    if (valid) begin
      if (temp > T_CRIT_HI) begin
        nxt_state = COOL;
        nxt_crit  = 1'b1;
      end else if (temp < T_CRIT_LO) begin
        nxt_state = HEAT;
        nxt_crit  = 1'b1;
      end else if (dwell_ok) begin
        case (state)
          IDLE: begin
            if (temp < T_HEAT_ON)      nxt_state = HEAT;
            else if (temp > T_COOL_ON) nxt_state = COOL;
          end
          HEAT:    if (temp > T_HEAT_OFF) nxt_state = IDLE;
          COOL:    if (temp < T_COOL_OFF) nxt_state = IDLE;
          default: nxt_state = IDLE;
        endcase
      end
    end
  end

  assign change = (nxt_state != state);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= CNT_MAX;
      dwell_ok <= 1'b1;
      mode_chg <= 1'b0;
      crit     <= 1'b0;
    end else begin
      state    <= nxt_state;
      mode_chg <= change;
      crit     <= change & nxt_crit;
      if (change) begin
        cnt      <= '0;
        dwell_ok <= 1'b0;
      end else if (cnt != CNT_MAX) begin
        cnt      <= cnt + CNT_W'(1);
        dwell_ok <= ((cnt + CNT_W'(1)) == CNT_MAX);
      end
    end
  end

  assign mode = state;
endmodule

`default_nettype wire

// File: rtl/thermo_ctrl_mc.sv
// ---------------------------------------------------------------------------
// thermo_ctrl_mc : N_CH independent thermostat channels on a shared bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module thermo_ctrl_mc
  import thermo_pkg::*;
#(
  parameter int TEMP_W    = 5,
  parameter int N_CH      = 2,
  parameter int HEAT_ON   = 12,
  parameter int COOL_ON   = 18,
  parameter int HEAT_OFF  = 20,
  parameter int COOL_OFF  = 14,
  parameter int CRIT_HI   = 26,
  parameter int CRIT_LO   = 8,
  parameter int DWELL_CYC = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  thermo_ctrl_mc_if.slave   bus
);
  localparam int T_MAX = (2 ** TEMP_W) - 1;

  if (!(CRIT_LO < COOL_OFF)) begin : g_chk_crit_lo
    $fatal(1, "thermo_ctrl_mc: CRIT_LO must be below COOL_OFF");
  end
  if (!(HEAT_ON < COOL_ON)) begin : g_chk_on
    $fatal(1, "thermo_ctrl_mc: HEAT_ON must be below COOL_ON");
  end
  if (!(HEAT_OFF < CRIT_HI)) begin : g_chk_crit_hi
    $fatal(1, "thermo_ctrl_mc: HEAT_OFF must be below CRIT_HI");
  end
  if (HEAT_ON > T_MAX || COOL_ON > T_MAX || HEAT_OFF > T_MAX ||
      COOL_OFF > T_MAX || CRIT_HI > T_MAX || CRIT_LO > T_MAX) begin : g_chk_range
    $fatal(1, "thermo_ctrl_mc: threshold exceeds TEMP_W range");
  end
  if (DWELL_CYC < 1) begin : g_chk_dwell
    $fatal(1, "thermo_ctrl_mc: DWELL_CYC must be at least 1");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    thermo_chan #(
      .TEMP_W   (TEMP_W),
      .HEAT_ON  (HEAT_ON),
      .COOL_ON  (COOL_ON),
      .HEAT_OFF (HEAT_OFF),
      .COOL_OFF (COOL_OFF),
      .CRIT_HI  (CRIT_HI),
      .CRIT_LO  (CRIT_LO),
      .DWELL_CYC(DWELL_CYC)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .valid   (bus.temp_valid[i]),
      .temp    (bus.temp[i*TEMP_W +: TEMP_W]),
      .mode    (bus.mode[i*MODE_W +: MODE_W]),
      .mode_chg(bus.mode_chg[i]),
      .crit    (bus.crit[i]),
      .dwell_ok(bus.dwell_ok[i])
    );
  end
endmodule

`default_nettype wire

// File: tb/tb_thermo_ctrl_mc.sv
// ---------------------------------------------------------------------------
// tb_thermo_ctrl_mc : directed vector bench for default and 8-bit/4-channel builds
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_thermo_ctrl_mc;
  import thermo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  thermo_ctrl_mc_if #(.N_CH(2), .TEMP_W(5)) bus ();
  thermo_ctrl_mc_if #(.N_CH(4), .TEMP_W(8)) bus8 ();

  thermo_ctrl_mc dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  thermo_ctrl_mc #(
    .TEMP_W(8), .N_CH(4), .HEAT_ON(96), .COOL_ON(144), .HEAT_OFF(160),
    .COOL_OFF(112), .CRIT_HI(208), .CRIT_LO(64), .DWELL_CYC(1)
  ) dut8 (
    .clk(clk),
    .rst(rst),
    .bus(bus8)
  );

  typedef struct {
    logic [1:0] valid;
    logic [4:0] t0;
    logic [4:0] t1;
    logic [3:0] mode;
    logic [1:0] chg;
    logic [1:0] crit;
    logic [1:0] ok;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [3:0] m, input logic [1:0] c,
                         input logic [1:0] cr, input logic [1:0] ok);
    chk({tag, ".mode"},     32'(bus.mode),     32'(m));
    chk({tag, ".mode_chg"}, 32'(bus.mode_chg), 32'(c));
    chk({tag, ".crit"},     32'(bus.crit),     32'(cr));
    chk({tag, ".dwell_ok"}, 32'(bus.dwell_ok), 32'(ok));
  endtask

  task automatic chk_bus8(input string tag, input logic [7:0] m, input logic [3:0] c,
                          input logic [3:0] cr, input logic [3:0] ok);
    chk({tag, ".mode"},     32'(bus8.mode),     32'(m));
    chk({tag, ".mode_chg"}, 32'(bus8.mode_chg), 32'(c));
    chk({tag, ".crit"},     32'(bus8.crit),     32'(cr));
    chk({tag, ".dwell_ok"}, 32'(bus8.dwell_ok), 32'(ok));
  endtask

  initial begin
    // valid, t0, t1, mode{ch1,ch0}, mode_chg, crit, dwell_ok
    vecs[0]  = '{2'b01, 5'd10, 5'd0, 4'b0010, 2'b01, 2'b00, 2'b10}; // IDLE->HEAT
    vecs[1]  = '{2'b01, 5'd21, 5'd0, 4'b0010, 2'b00, 2'b00, 2'b10}; // blocked by dwell
    vecs[2]  = '{2'b01, 5'd21, 5'd0, 4'b0010, 2'b00, 2'b00, 2'b10};
    vecs[3]  = '{2'b01, 5'd21, 5'd0, 4'b0010, 2'b00, 2'b00, 2'b10};
    vecs[4]  = '{2'b01, 5'd21, 5'd0, 4'b0010, 2'b00, 2'b00, 2'b11}; // edge e+4: still HEAT
    vecs[5]  = '{2'b01, 5'd21, 5'd0, 4'b0000, 2'b01, 2'b00, 2'b10}; // edge e+5: IDLE
    vecs[6]  = '{2'b00, 5'd0,  5'd0, 4'b0000, 2'b00, 2'b00, 2'b10};
    vecs[7]  = '{2'b00, 5'd0,  5'd0, 4'b0000, 2'b00, 2'b00, 2'b10};
    vecs[8]  = '{2'b00, 5'd0,  5'd0, 4'b0000, 2'b00, 2'b00, 2'b10};
    vecs[9]  = '{2'b00, 5'd0,  5'd0, 4'b0000, 2'b00, 2'b00, 2'b11};
    vecs[10] = '{2'b01, 5'd12, 5'd0, 4'b0000, 2'b00, 2'b00, 2'b11}; // equal HEAT_ON holds
    vecs[11] = '{2'b01, 5'd18, 5'd0, 4'b0000, 2'b00, 2'b00, 2'b11}; // equal COOL_ON holds
    vecs[12] = '{2'b01, 5'd19, 5'd0, 4'b0001, 2'b01, 2'b00, 2'b10}; // IDLE->COOL
    vecs[13] = '{2'b00, 5'd0,  5'd0, 4'b0001, 2'b00, 2'b00, 2'b10};
    vecs[14] = '{2'b00, 5'd0,  5'd0, 4'b0001, 2'b00, 2'b00, 2'b10};
    vecs[15] = '{2'b00, 5'd0,  5'd0, 4'b0001, 2'b00, 2'b00, 2'b10};
    vecs[16] = '{2'b00, 5'd0,  5'd0, 4'b0001, 2'b00, 2'b00, 2'b11};
    vecs[17] = '{2'b01, 5'd14, 5'd0, 4'b0001, 2'b00, 2'b00, 2'b11}; // equal COOL_OFF holds
    vecs[18] = '{2'b01, 5'd15, 5'd0, 4'b0001, 2'b00, 2'b00, 2'b11};
    vecs[19] = '{2'b01, 5'd13, 5'd0, 4'b0000, 2'b01, 2'b00, 2'b10}; // COOL->IDLE
    vecs[20] = '{2'b01, 5'd7,  5'd0, 4'b0010, 2'b01, 2'b01, 2'b10}; // crit low, ignores dwell
    vecs[21] = '{2'b01, 5'd27, 5'd0, 4'b0001, 2'b01, 2'b01, 2'b10}; // crit high 1 cycle after entry
    vecs[22] = '{2'b01, 5'd30, 5'd0, 4'b0001, 2'b00, 2'b00, 2'b10}; // crit to same state: no pulse
    vecs[23] = '{2'b11, 5'd20, 5'd25, 4'b0101, 2'b10, 2'b00, 2'b00}; // ch1 COOL, ch0 blocked
    vecs[24] = '{2'b10, 5'd0,  5'd3, 4'b1001, 2'b10, 2'b10, 2'b00}; // ch1 crit low
    vecs[25] = '{2'b01, 5'd10, 5'd0, 4'b1001, 2'b00, 2'b00, 2'b01}; // ch0 sample dropped
    vecs[26] = '{2'b00, 5'd0,  5'd0, 4'b1001, 2'b00, 2'b00, 2'b01}; // not queued
    vecs[27] = '{2'b01, 5'd10, 5'd0, 4'b1000, 2'b01, 2'b00, 2'b00}; // ch0 COOL->IDLE

    // Reset held with live inputs
    rst = 1'b1;
    bus.temp_valid  = 2'b11;
    bus.temp        = {5'd3, 5'd30};
    bus8.temp_valid = 4'b1111;
    bus8.temp       = {8'd10, 8'd250, 8'd10, 8'd250};
    repeat (2) @(posedge clk);
    #1;
    chk_bus("reset", 4'b0000, 2'b00, 2'b00, 2'b11);
    chk_bus8("reset8", 8'h00, 4'h0, 4'h0, 4'hF);

    rst = 1'b0;
    bus.temp_valid  = 2'b00;
    bus8.temp_valid = 4'b0000;

    for (int i = 0; i < NV; i++) begin
      bus.temp_valid = vecs[i].valid;
      bus.temp       = {vecs[i].t1, vecs[i].t0};
      @(posedge clk);
      #1;
      chk_bus($sformatf("vec%0d", i), vecs[i].mode, vecs[i].chg, vecs[i].crit, vecs[i].ok);
    end

    // Asynchronous reset between edges, mid-dwell
    bus.temp_valid = 2'b00;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk_bus("async_rst", 4'b0000, 2'b00, 2'b00, 2'b11);
    @(posedge clk);
    #1 rst = 1'b0;

    // Wide build: simultaneous valids on all channels
    bus8.temp_valid = 4'b1111;
    bus8.temp       = {8'd220, 8'd120, 8'd150, 8'd90};
    @(posedge clk);
    #1;
    chk_bus8("par_all", 8'b01_00_01_10, 4'b1011, 4'b1000, 4'b0100);

    // DWELL_CYC=1: the sample right after entry is blocked, the next one exits
    bus8.temp_valid = 4'b0001;
    bus8.temp       = {8'd0, 8'd0, 8'd0, 8'd161};
    @(posedge clk);
    #1;
    chk_bus8("par_blk", 8'b01_00_01_10, 4'b0000, 4'b0000, 4'b1111);
    @(posedge clk);
    #1;
    chk_bus8("par_exit", 8'b01_00_01_00, 4'b0001, 4'b0000, 4'b1110);
    bus8.temp_valid = 4'b0000;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
